// File: rtl/pe_psum_accumulator_pkg.sv
// Shared constants and FSM encoding for the PE partial-sum accumulator.
package pe_psum_accumulator_pkg;

    localparam int PSUM_W_DEF = 20;
    localparam int DEPTH_DEF  = 16;
    localparam int AW_DEF     = 4;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/pe_psum_accumulator_regfile.sv
// DEPTH x W partial-sum storage: one write port, two asynchronous read ports.
module psum_regfile #(
    parameter int W     = 20,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    output logic [W-1:0]  o_rdata_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [W-1:0]  o_rdata_b
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/pe_psum_accumulator.sv
// Partial-sum accumulator: feeds previous_sum to the PE adder, stores each step,
// then drains the final per-channel sums over a valid/ready stream.
module pe_psum_accumulator
    import pe_psum_accumulator_pkg::*;
#(
    parameter int PSUM_W = PSUM_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = AW_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_acc_len,
    input  logic [AW:0]       cfg_num_out,
    input  logic              pe_valid,
    input  logic [PSUM_W-1:0] pe_sum,
    output logic [PSUM_W-1:0] previous_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PSUM_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [AW-1:0]     r_wr_idx;
    logic [AW-1:0]     r_rd_idx;
    logic [AW-1:0]     r_last_idx;
    logic [LEN_W-1:0]  r_pass;
    logic [LEN_W-1:0]  r_last_pass;
    logic              r_done;

    logic              w_start;
    logic              w_step;
    logic              w_row_end;
    logic              w_pass_end;
    logic              w_hs;
    logic              w_rd_last;
    logic [AW:0]       w_num_m1;
    logic [AW-1:0]     w_last_idx_cfg;
    logic [LEN_W-1:0]  w_last_pass_cfg;
    logic [PSUM_W-1:0] w_wr_rdata;
    logic [PSUM_W-1:0] w_rd_rdata;

    // Zero or oversized entry counts mean "use every entry"; zero passes mean one.
    assign w_num_m1        = cfg_num_out - {{AW{1'b0}}, 1'b1};
    assign w_last_idx_cfg  = ((cfg_num_out == '0) || (cfg_num_out > (AW+1)'(DEPTH)))
                             ? AW'(DEPTH - 1) : w_num_m1[AW-1:0];
    assign w_last_pass_cfg = (cfg_acc_len == '0) ? '0 : cfg_acc_len - LEN_W'(1);

    assign w_start    = (r_state == ST_IDLE) && start;
    assign w_step     = (r_state == ST_ACCUM) && pe_valid;
    assign w_row_end  = (r_wr_idx == r_last_idx);
    assign w_pass_end = (r_pass == r_last_pass);
    // Drain stream: a word transfers on any cycle where out_valid and out_ready
    // are both high; while out_ready is low the word and out_last stay put.
    assign w_hs       = (r_state == ST_DRAIN) && out_ready;
    assign w_rd_last  = (r_rd_idx == r_last_idx);

    psum_regfile #(
        .W     (PSUM_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_step),
        .i_waddr   (r_wr_idx),
        .i_wdata   (pe_sum),
        .i_raddr_a (r_wr_idx),
        .o_rdata_a (w_wr_rdata),
        .i_raddr_b (r_rd_idx),
        .o_rdata_b (w_rd_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_ACCUM;
            ST_ACCUM: if (w_step && w_row_end && w_pass_end) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_hs && w_rd_last) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_pass      <= '0;
            r_last_idx  <= '0;
            r_last_pass <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_hs && w_rd_last;
            if (w_start) begin
                r_wr_idx    <= '0;
                r_rd_idx    <= '0;
                r_pass      <= '0;
                r_last_idx  <= w_last_idx_cfg;
                r_last_pass <= w_last_pass_cfg;
            end
            if (w_step) begin
                if (w_row_end) begin
                    r_wr_idx <= '0;
                    if (!w_pass_end) r_pass <= r_pass + LEN_W'(1);
                end else begin
                    r_wr_idx <= r_wr_idx + AW'(1);
                end
            end
            if (w_hs) begin
                r_rd_idx <= r_rd_idx + AW'(1);
            end
        end
    end

    // Pass 0 starts every channel from zero, so stale entries from a prior job never leak in.
    assign previous_sum = ((r_state == ST_ACCUM) && (r_pass != '0)) ? w_wr_rdata : '0;
    assign out_valid    = (r_state == ST_DRAIN);
    assign out_data     = (r_state == ST_DRAIN) ? w_rd_rdata : '0;
    assign out_last     = (r_state == ST_DRAIN) && w_rd_last;
    assign busy         = (r_state == ST_ACCUM) || (r_state == ST_DRAIN);
    assign done         = r_done;

endmodule
